// File: rtl/ram_dp_param.sv
// ram_dp_param: true dual-port RAM with byte enables, selectable write mode and optional output register
module ram_dp_param #(
  parameter int DATA_W     = 16,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       enb,
  input  logic [DATA_W/BYTE_W-1:0]   wea,
  input  logic [DATA_W/BYTE_W-1:0]   web,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [ADDR_W-1:0]          addrb,
  input  logic [DATA_W-1:0]          dia,
  input  logic [DATA_W-1:0]          dib,
  output logic [DATA_W-1:0]          douta,
  output logic [DATA_W-1:0]          doutb,
  output logic                       valida,
  output logic                       validb,
  output logic                       collision
);
  localparam int NB = DATA_W / BYTE_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_a, in_b, wcy_a, wcy_b, wr_a, wr_b, same, coll, upd_a, upd_b;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, nxt_a, nxt_b;
  logic [DATA_W-1:0] d1a, d1b;
  logic v1a, v1b, c1;
  assign in_a  = int'(addra) < DEPTH;
  assign in_b  = int'(addrb) < DEPTH;
  assign wcy_a = ena & |wea;
  assign wcy_b = enb & |web;
  assign wr_a  = rst_n & wcy_a & in_a;
  assign wr_b  = rst_n & wcy_b & in_b;
  assign same  = addra == addrb;
  assign coll  = ena & enb & same & in_a & (|wea | |web);
  assign old_a = in_a ? mem[addra] : '0;
  assign old_b = in_b ? mem[addrb] : '0;
  // new_a folds in B's lanes on a shared address so it is the full post-write word
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      new_b[i*BYTE_W +: BYTE_W] = web[i] ? dib[i*BYTE_W +: BYTE_W] : old_b[i*BYTE_W +: BYTE_W];
      new_a[i*BYTE_W +: BYTE_W] = wea[i] ? dia[i*BYTE_W +: BYTE_W] :
                                  (same & wr_b & web[i]) ? dib[i*BYTE_W +: BYTE_W] : old_a[i*BYTE_W +: BYTE_W];
    end
  end
  assign nxt_a = !wcy_a ? old_a : WRITE_MODE == 1 ? old_a : in_a ? new_a : '0;
  assign nxt_b = !wcy_b ? old_b : WRITE_MODE == 1 ? old_b : !in_b ? '0 : (same & wr_a) ? new_a : new_b;
  assign upd_a = ena & ~(wcy_a & (WRITE_MODE == 0));
  assign upd_b = enb & ~(wcy_b & (WRITE_MODE == 0));
  always_ff @(posedge clk) begin
    if (wr_b) mem[addrb] <= new_b;
    if (wr_a) mem[addra] <= new_a;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1a <= '0;
      d1b <= '0;
      v1a <= 1'b0;
      v1b <= 1'b0;
      c1  <= 1'b0;
    end else begin
      if (upd_a) d1a <= nxt_a;
      if (upd_b) d1b <= nxt_b;
      v1a <= upd_a;
      v1b <= upd_b;
      c1  <= coll;
    end
  end
  if (OUT_REG != 0) begin : g_reg
    logic [DATA_W-1:0] d2a, d2b;
    logic v2a, v2b, c2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2a <= '0;
        d2b <= '0;
        v2a <= 1'b0;
        v2b <= 1'b0;
        c2  <= 1'b0;
      end else begin
        d2a <= d1a;
        d2b <= d1b;
        v2a <= v1a;
        v2b <= v1b;
        c2  <= c1;
      end
    end
    assign douta     = d2a;
    assign doutb     = d2b;
    assign valida    = v2a;
    assign validb    = v2b;
    assign collision = c2;
  end else begin : g_dir
    assign douta     = d1a;
    assign doutb     = d1b;
    assign valida    = v1a;
    assign validb    = v1b;
    assign collision = c1;
  end
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: four configurations share one stimulus stream and are checked against a word/lane memory model
module tb_ram_dp_param;
  logic clk = 0, rst_n = 1, ena = 0, enb = 0;
  logic [1:0] wea = 0, web = 0;
  logic [9:0] addra = 0, addrb = 0;
  logic [15:0] dia = 0, dib = 0;
  logic [15:0] da [4], db [4];
  logic va [4], vb [4], co [4];
  int n_cmp = 0, n_err = 0;
  localparam int MODE [4] = '{0, 1, 2, 1};
  logic [9:0] pool [12] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007,
                            10'h3E8, 10'h3F0, 10'h3FF, 10'h010};
  logic [15:0] mm [2][1024];
  logic [15:0] sd [2][4][2];
  logic sv [2][4][2];
  logic sc [2][4];

  always #5 clk = ~clk;

  ram_dp_param #(.WRITE_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .douta(da[0]), .doutb(db[0]),
    .valida(va[0]), .validb(vb[0]), .collision(co[0]));
  ram_dp_param #(.WRITE_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .douta(da[1]), .doutb(db[1]),
    .valida(va[1]), .validb(vb[1]), .collision(co[1]));
  ram_dp_param #(.WRITE_MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .douta(da[2]), .doutb(db[2]),
    .valida(va[2]), .validb(vb[2]), .collision(co[2]));
  ram_dp_param #(.WRITE_MODE(1), .OUT_REG(1), .DEPTH(1000)) u3 (.clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb),
    .wea(wea), .web(web), .addra(addra), .addrb(addrb), .dia(dia), .dib(dib), .douta(da[3]), .doutb(db[3]),
    .valida(va[3]), .validb(vb[3]), .collision(co[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    int s;
    for (int k = 0; k < 4; k++) begin
      s = (k == 3) ? 1 : 0;
      chk($sformatf("u%0d", k), {co[k], vb[k], va[k], db[k], da[k]},
          {sc[s][k], sv[s][k][1], sv[s][k][0], sd[s][k][1], sd[s][k][0]});
    end
  endtask

  task automatic clr_model();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) begin
        sc[s][k] = 0;
        for (int p = 0; p < 2; p++) begin
          sd[s][k][p] = 0;
          sv[s][k][p] = 0;
        end
      end
  endtask

  task automatic step();
    logic [9:0] ad [2];
    logic en [2], wr [2], col [2];
    logic [1:0] we [2];
    logic [15:0] di [2];
    logic [15:0] old [2][2], nw [2][2];
    int dep, g;
    @(posedge clk);
    if (rst_n) begin
      ad[0] = addra; ad[1] = addrb; en[0] = ena; en[1] = enb;
      we[0] = wea; we[1] = web; di[0] = dia; di[1] = dib;
      for (int p = 0; p < 2; p++) wr[p] = en[p] && we[p] != 0;
      for (int m = 0; m < 2; m++) begin
        dep = m ? 1000 : 1024;
        for (int p = 0; p < 2; p++) old[m][p] = (int'(ad[p]) < dep) ? mm[m][ad[p]] : 16'h0;
        col[m] = en[0] && en[1] && ad[0] == ad[1] && int'(ad[0]) < dep && (wr[0] || wr[1]);
        for (int p = 1; p >= 0; p--)
          if (wr[p] && int'(ad[p]) < dep)
            for (int l = 0; l < 2; l++)
              if (we[p][l]) mm[m][ad[p]][l*8 +: 8] = di[p][l*8 +: 8];
        for (int p = 0; p < 2; p++) nw[m][p] = (int'(ad[p]) < dep) ? mm[m][ad[p]] : 16'h0;
      end
      for (int k = 0; k < 4; k++) begin
        g = (k == 3) ? 1 : 0;
        sd[1][k] = sd[0][k];
        sv[1][k] = sv[0][k];
        sc[1][k] = sc[0][k];
        sc[0][k] = col[g];
        for (int p = 0; p < 2; p++) begin
          if (!en[p]) sv[0][k][p] = 0;
          else if (!wr[p]) begin
            sd[0][k][p] = old[g][p];
            sv[0][k][p] = 1;
          end else if (MODE[k] == 0) sv[0][k][p] = 0;
          else begin
            sd[0][k][p] = (MODE[k] == 1) ? old[g][p] : nw[g][p];
            sv[0][k][p] = 1;
          end
        end
      end
    end
    #1 compare_all();
  endtask

  task automatic acc(input logic ea, input logic [1:0] wa, input logic [9:0] aa, input logic [15:0] xa,
                     input logic eb, input logic [1:0] wb, input logic [9:0] ab, input logic [15:0] xb);
    ena = ea; wea = wa; addra = aa; dia = xa;
    enb = eb; web = wb; addrb = ab; dib = xb;
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #1 clr_model();
    compare_all();
    step();
    rst_n = 1;
  endtask

  task automatic rand_in();
    ena = $urandom_range(0, 3) != 0;
    enb = $urandom_range(0, 3) != 0;
    wea = $urandom_range(0, 1) ? 2'($urandom) : 2'b00;
    web = $urandom_range(0, 1) ? 2'($urandom) : 2'b00;
    addra = pool[$urandom_range(0, 11)];
    addrb = $urandom_range(0, 2) == 0 ? addra : pool[$urandom_range(0, 11)];
    dia = 16'($urandom);
    dib = 16'($urandom);
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 1024; a++) mm[m][a] = 0;
    clr_model();
    #1 rst_n = 0;
    #1 compare_all();
    step();
    step();
    rst_n = 1;
    foreach (pool[i]) acc(1, 2'b11, pool[i], 16'($urandom), 0, 0, 0, 0);
    acc(1, 2'b11, 10'h005, 16'h1234, 0, 0, 0, 0);
    acc(1, 2'b00, 10'h005, 0, 0, 0, 0, 0);
    chk("rd_005", {va[0], da[0]}, {1'b1, 16'h1234});
    acc(1, 2'b11, 10'h1A0, 16'hABCD, 0, 0, 0, 0);
    acc(0, 0, 0, 0, 1, 2'b01, 10'h1A0, 16'h55EE);
    acc(1, 2'b00, 10'h1A0, 0, 0, 0, 0, 0);
    chk("lane", {va[0], da[0]}, {1'b1, 16'hABEE});
    acc(1, 2'b11, 10'h010, 16'h1111, 0, 0, 0, 0);
    acc(1, 2'b00, 10'h010, 0, 0, 0, 0, 0);
    acc(1, 2'b11, 10'h010, 16'h2222, 0, 0, 0, 0);
    chk("mode0", {va[0], da[0]}, {1'b0, 16'h1111});
    chk("mode1", {va[1], da[1]}, {1'b1, 16'h1111});
    chk("mode2", {va[2], da[2]}, {1'b1, 16'h2222});
    acc(1, 2'b10, 10'h020, 16'hAAAA, 1, 2'b11, 10'h020, 16'hBBBB);
    chk("col_ww", co[0], 1);
    acc(1, 2'b00, 10'h020, 0, 0, 0, 0, 0);
    chk("col_rd", {co[0], va[0], da[0]}, {1'b0, 1'b1, 16'hAABB});
    acc(1, 2'b11, 10'h020, 16'h1234, 1, 2'b00, 10'h020, 0);
    chk("col_wr", {co[1], vb[1], db[1]}, {1'b1, 1'b1, 16'hAABB});
    for (int i = 0; i < 14; i++) begin
      if (i == 6) pulse_reset();
      acc(1, 2'b00, 10'(i % 4), 0, 1, 2'b00, 10'((i + 1) % 4), 0);
      if (i == 6) chk("pipe_rst", {va[3], vb[3]}, 2'b00);
    end
    acc(1, 2'b11, 10'h3F0, 16'h9999, 1, 2'b00, 10'h3F0, 0);
    chk("oor_col", co[0], 1);
    acc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("oor_wr", {co[3], vb[3], db[3]}, {1'b0, 1'b1, 16'h0});
    acc(1, 2'b00, 10'h3F0, 0, 0, 0, 0, 0);
    acc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("oor_rd", {co[3], va[3], da[3]}, {1'b0, 1'b1, 16'h0});
    for (int i = 0; i < 400; i++) begin
      rand_in();
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
